// File: rtl/processor_core.sv
// Multi-cycle 16-bit load/store processor on a shared single-port synchronous RAM.
// Define PROCESSOR_MUL_EN to build the opcode-1 multiplier; otherwise opcode 1 is a no-op.
module processor_core #(
    parameter int unsigned INSTRUCTION_SIZE     = 16,
    parameter int unsigned REGISTER_SIZE        = 16,
    parameter int unsigned REGISTER_BANK_SIZE   = 16,
    parameter int unsigned MEMORY_ADDRESS_WIDTH = 8
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [INSTRUCTION_SIZE-1:0]     i_ram_read_data,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] o_ram_address,
    output logic [REGISTER_SIZE-1:0]        o_ram_write_data,
    output logic                            o_ram_write_enable,
    output logic                            o_halted
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteBack,
        StHalt
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_LW  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    state_t current_state;
    state_t next_state;

    logic [MEMORY_ADDRESS_WIDTH-1:0] r_pc;
    logic [INSTRUCTION_SIZE-1:0]     r_ir;
    logic [REGISTER_SIZE-1:0]        r_result;
    logic [REGISTER_SIZE-1:0]        r_registers [REGISTER_BANK_SIZE];

    logic [2:0]                      w_opcode;
    logic                            w_imm_form;
    logic [3:0]                      w_rd;
    logic [3:0]                      w_rs1;
    logic [3:0]                      w_rs2;
    logic [7:0]                      w_imm;
    logic [REGISTER_SIZE-1:0]        w_rd_value;
    logic [REGISTER_SIZE-1:0]        w_rs1_value;
    logic [REGISTER_SIZE-1:0]        w_operand_a;
    logic [REGISTER_SIZE-1:0]        w_operand_b;
    logic [3:0]                      w_rotate_amount;
    logic [4:0]                      w_rotate_complement;
    logic [REGISTER_SIZE-1:0]        w_rotl;
    logic [REGISTER_SIZE-1:0]        w_rotr;
    logic [REGISTER_SIZE-1:0]        w_alu_result;
    logic [MEMORY_ADDRESS_WIDTH-1:0] w_mem_address;
    logic                            w_writes_rd;
    logic                            w_reg_write_enable;
    logic [REGISTER_SIZE-1:0]        w_reg_write_data;

    assign w_opcode   = r_ir[15:13];
    assign w_imm_form = r_ir[12];
    assign w_rd       = r_ir[11:8];
    assign w_rs1      = r_ir[7:4];
    assign w_rs2      = r_ir[3:0];
    assign w_imm      = r_ir[7:0];

    assign w_rd_value  = r_registers[w_rd];
    assign w_rs1_value = r_registers[w_rs1];

    // Immediate form uses rd as both the first source and the destination.
    assign w_operand_a = w_imm_form ? w_rd_value : w_rs1_value;
    assign w_operand_b = w_imm_form ? {{(REGISTER_SIZE-8){1'b0}}, w_imm} : r_registers[w_rs2];

    assign w_mem_address = w_imm_form ? w_imm : w_rs1_value[MEMORY_ADDRESS_WIDTH-1:0];

    // A zero amount makes the complementary shift a full-width shift, which yields zero.
    assign w_rotate_amount     = w_operand_b[3:0];
    assign w_rotate_complement = 5'(REGISTER_SIZE) - {1'b0, w_rotate_amount};
    assign w_rotl = (w_operand_a << w_rotate_amount) | (w_operand_a >> w_rotate_complement);
    assign w_rotr = (w_operand_a >> w_rotate_amount) | (w_operand_a << w_rotate_complement);

    always_comb begin
        w_alu_result = '0;
        case (w_opcode)
            OP_ADD: w_alu_result = w_operand_a + w_operand_b;
`ifdef PROCESSOR_MUL_EN
            OP_MUL: w_alu_result = w_operand_a * w_operand_b;
`endif
            OP_AND: w_alu_result = w_operand_a & w_operand_b;
            OP_OR:  w_alu_result = w_operand_a | w_operand_b;
            OP_SHL: w_alu_result = w_rotl;
            OP_SHR: w_alu_result = w_rotr;
            default: w_alu_result = '0;
        endcase
    end

`ifdef PROCESSOR_MUL_EN
    assign w_writes_rd = (w_opcode != OP_SW);
`else
    assign w_writes_rd = (w_opcode != OP_SW) && (w_opcode != OP_MUL);
`endif

    assign w_reg_write_enable = (current_state == StWriteBack) && w_writes_rd;
    assign w_reg_write_data   = (w_opcode == OP_LW) ? i_ram_read_data : r_result;

    always_comb begin
        next_state = current_state;
        unique case (current_state)
            StFetch:     next_state = StDecode;
            StDecode:    next_state = (i_ram_read_data == '0) ? StHalt : StExecute;
            StExecute:   next_state = StWriteBack;
            StWriteBack: next_state = StFetch;
            StHalt:      next_state = StHalt;
            default:     next_state = StFetch;
        endcase
    end

    always_comb begin
        o_ram_address      = '0;
        o_ram_write_data   = '0;
        o_ram_write_enable = 1'b0;
        o_halted           = 1'b0;
        unique case (current_state)
            StFetch: o_ram_address = r_pc;
            StExecute: begin
                if (w_opcode == OP_LW || w_opcode == OP_SW) begin
                    o_ram_address = w_mem_address;
                end
                if (w_opcode == OP_SW) begin
                    o_ram_write_data   = w_rd_value;
                    o_ram_write_enable = 1'b1;
                end
            end
            StHalt:  o_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            current_state <= StFetch;
            r_pc          <= '0;
            r_ir          <= '0;
            r_result      <= '0;
        end else begin
            current_state <= next_state;
            if (current_state == StDecode) begin
                r_ir <= i_ram_read_data;
                r_pc <= r_pc + MEMORY_ADDRESS_WIDTH'(1);
            end
            if (current_state == StExecute) begin
                r_result <= w_alu_result;
            end
        end
    end

    // Register contents survive reset, so the bank has no reset term.
    always_ff @(posedge i_clock) begin
        if (w_reg_write_enable) begin
            r_registers[w_rd] <= w_reg_write_data;
        end
    end

endmodule

// File: tb/tb_processor_core.sv
// Self-checking bench for processor_core: table-driven single-instruction programs plus
// directed sequences for reset, store, halt and reset-during-store behaviour.
module tb_processor_core;

`ifdef PROCESSOR_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] name;
        logic [15:0]  instr;
        logic [15:0]  a;
        logic [15:0]  b;
        logic [15:0]  c;
        logic [7:0]   check_addr;
        logic [15:0]  expected;
    } vec_t;

    localparam int NUM_VECS = 25;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [15:0] ram_read_data;
    logic [7:0]  ram_address;
    logic [15:0] ram_write_data;
    logic        ram_write_enable;
    logic        halted;

    logic [15:0] mem [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    vec_t vecs [NUM_VECS];

    processor_core dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_ram_read_data    (ram_read_data),
        .o_ram_address      (ram_address),
        .o_ram_write_data   (ram_write_data),
        .o_ram_write_enable (ram_write_enable),
        .o_halted           (halted)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with a side load path for the bench.
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (ram_write_enable) mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address];
    end

    always @(posedge clk) begin
        if (ram_write_enable) we_count <= we_count + 1;
    end

    function automatic logic [15:0] rform(input logic [2:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2};
    endfunction

    function automatic logic [15:0] iform(input logic [2:0] op, input logic [3:0] rd,
                                          input logic [7:0] imm);
        return {op, 1'b1, rd, imm};
    endfunction

    function automatic vec_t mk(input logic [127:0] name, input logic [15:0] instr,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [7:0] check_addr,
                                input logic [15:0] expected);
        vec_t v;
        v.name = name; v.instr = instr; v.a = a; v.b = b; v.c = c;
        v.check_addr = check_addr; v.expected = expected;
        return v;
    endfunction

    task automatic check(input logic [127:0] name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    task automatic wait_halt(input int bound, input logic [127:0] name);
        int n = 0;
        while (!halted && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic run_vector(input vec_t v);
        i_reset = 1'b0;
        load_word(8'd0, iform(3'd6, 4'd1, 8'd200));
        load_word(8'd1, iform(3'd6, 4'd2, 8'd201));
        load_word(8'd2, iform(3'd6, 4'd3, 8'd203));
        load_word(8'd3, v.instr);
        load_word(8'd4, iform(3'd7, 4'd3, 8'd202));
        load_word(8'd5, 16'h0000);
        load_word(8'd200, v.a);
        load_word(8'd201, v.b);
        load_word(8'd203, v.c);
        load_word(8'd202, 16'hDEAD);
        load_word(8'd204, 16'hDEAD);
        release_reset();
        wait_halt(60, "vec_halt");
        check(v.name, {16'd0, mem[v.check_addr]}, {16'd0, v.expected});
    endtask

    initial begin
        int wc0;
        int wc1;
        int n;
        logic [15:0] exp_mul;

        vecs[0]  = mk("add_reg",  rform(3'd0, 4'd3, 4'd1, 4'd2), 16'h1234, 16'h0F0F, 16'h0000, 8'd202, 16'h2143);
        vecs[1]  = mk("add_wrap", rform(3'd0, 4'd3, 4'd1, 4'd2), 16'hFFFF, 16'h0002, 16'h0000, 8'd202, 16'h0001);
        vecs[2]  = mk("mul_reg",  rform(3'd1, 4'd3, 4'd1, 4'd2), 16'h0103, 16'h0105, 16'h5555, 8'd202,
                      MUL_ON ? 16'h080F : 16'h5555);
        vecs[3]  = mk("and_reg",  rform(3'd2, 4'd3, 4'd1, 4'd2), 16'hF0F0, 16'h3C3C, 16'h0000, 8'd202, 16'h3030);
        vecs[4]  = mk("or_reg",   rform(3'd3, 4'd3, 4'd1, 4'd2), 16'hF0F0, 16'h0C03, 16'h0000, 8'd202, 16'hFCF3);
        vecs[5]  = mk("shl_reg",  rform(3'd4, 4'd3, 4'd1, 4'd2), 16'h8001, 16'h0001, 16'h0000, 8'd202, 16'h0003);
        vecs[6]  = mk("shr_reg",  rform(3'd5, 4'd3, 4'd1, 4'd2), 16'h1234, 16'h0004, 16'h0000, 8'd202, 16'h4123);
        vecs[7]  = mk("shl_zero", rform(3'd4, 4'd3, 4'd1, 4'd2), 16'hBEEF, 16'h0010, 16'h0000, 8'd202, 16'hBEEF);
        vecs[8]  = mk("shr_zero", rform(3'd5, 4'd3, 4'd1, 4'd2), 16'hBEEF, 16'h0020, 16'h0000, 8'd202, 16'hBEEF);
        vecs[9]  = mk("shr_15",   rform(3'd5, 4'd3, 4'd1, 4'd2), 16'h0001, 16'h000F, 16'h0000, 8'd202, 16'h0002);
        vecs[10] = mk("add_imm",  iform(3'd0, 4'd3, 8'hFF), 16'h0000, 16'h0000, 16'h7F01, 8'd202, 16'h8000);
        vecs[11] = mk("mul_imm",  iform(3'd1, 4'd3, 8'h03), 16'h0000, 16'h0000, 16'h0101, 8'd202,
                      MUL_ON ? 16'h0303 : 16'h0101);
        vecs[12] = mk("and_imm",  iform(3'd2, 4'd3, 8'h0F), 16'h0000, 16'h0000, 16'hABCD, 8'd202, 16'h000D);
        vecs[13] = mk("or_imm",   iform(3'd3, 4'd3, 8'h34), 16'h0000, 16'h0000, 16'h1200, 8'd202, 16'h1234);
        vecs[14] = mk("shl_imm",  iform(3'd4, 4'd3, 8'h14), 16'h0000, 16'h0000, 16'h1234, 8'd202, 16'h2341);
        vecs[15] = mk("shr_imm",  iform(3'd5, 4'd3, 8'h08), 16'h0000, 16'h0000, 16'h1234, 8'd202, 16'h3412);
        vecs[16] = mk("lw_reg",   rform(3'd6, 4'd3, 4'd1, 4'd0), 16'hABC9, 16'h5A5A, 16'h0000, 8'd202, 16'h5A5A);
        vecs[17] = mk("sw_reg",   rform(3'd7, 4'd2, 4'd1, 4'd0), 16'h12CC, 16'h6789, 16'h1111, 8'd204, 16'h6789);
        vecs[18] = mk("lw_imm",   iform(3'd6, 4'd3, 8'd201), 16'h0000, 16'h0F0F, 16'h0000, 8'd202, 16'h0F0F);
        vecs[19] = mk("add_self", rform(3'd0, 4'd3, 4'd3, 4'd3), 16'h0000, 16'h0000, 16'h4321, 8'd202, 16'h8642);
        vecs[20] = mk("mul_self", rform(3'd1, 4'd3, 4'd3, 4'd3), 16'h0000, 16'h0000, 16'h0102, 8'd202,
                      MUL_ON ? 16'h0404 : 16'h0102);
        vecs[21] = mk("and_self", rform(3'd2, 4'd3, 4'd3, 4'd3), 16'h0000, 16'h0000, 16'h9C3A, 8'd202, 16'h9C3A);
        vecs[22] = mk("or_self",  rform(3'd3, 4'd3, 4'd3, 4'd3), 16'h0000, 16'h0000, 16'h9C3A, 8'd202, 16'h9C3A);
        vecs[23] = mk("shl_self", rform(3'd4, 4'd3, 4'd3, 4'd3), 16'h0000, 16'h0000, 16'h1235, 8'd202, 16'h46A2);
        vecs[24] = mk("shr_self", rform(3'd5, 4'd3, 4'd3, 4'd3), 16'h0000, 16'h0000, 16'h00F3, 8'd202, 16'h601E);

        exp_mul = MUL_ON ? 16'h0004 : 16'h0077;

        // Sequence 1: reset state, first load, store, multiply, halt at address 26.
        load_en = 1'b0; load_addr = '0; load_data = '0;
        i_reset = 1'b1;
        #1 i_reset = 1'b0;
        #1;
        check("rst_addr", {24'd0, ram_address}, 32'd0);
        check("rst_wdata", {16'd0, ram_write_data}, 32'd0);
        check("rst_we", {31'd0, ram_write_enable}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", {24'd0, dut.r_pc}, 32'd0);
        check("rst_ir", {16'd0, dut.r_ir}, 32'd0);

        load_word(8'd0, iform(3'd6, 4'd1, 8'd101));
        load_word(8'd1, iform(3'd6, 4'd0, 8'd100));
        load_word(8'd2, rform(3'd0, 4'd2, 4'd1, 4'd1));
        load_word(8'd3, iform(3'd7, 4'd2, 8'd255));
        load_word(8'd4, iform(3'd6, 4'd3, 8'd102));
        load_word(8'd5, rform(3'd1, 4'd3, 4'd2, 4'd2));
        load_word(8'd6, iform(3'd7, 4'd3, 8'd254));
        for (int i = 7; i < 26; i++) load_word(8'(i), rform(3'd3, 4'd5, 4'd5, 4'd5));
        load_word(8'd26, 16'h0000);
        load_word(8'd100, 16'h0000);
        load_word(8'd101, 16'h0001);
        load_word(8'd102, 16'h0077);
        load_word(8'd254, 16'hDEAD);
        load_word(8'd255, 16'hDEAD);
        #1;
        wc0 = we_count;
        release_reset();
        repeat (4) @(posedge clk);
        #1;
        check("first_lw_r1", {16'd0, dut.r_registers[1]}, 32'd1);
        check("first_pc", {24'd0, dut.r_pc}, 32'd1);
        check("first_fetch_addr", {24'd0, ram_address}, 32'd1);

        wait_halt(300, "seq1_halt");
        check("halt_pc", {24'd0, dut.r_pc}, 32'd27);
        check("sw_mem255", {16'd0, mem[255]}, 32'd2);
        check("mul_mem254", {16'd0, mem[254]}, {16'd0, exp_mul});
        check("we_cycles", we_count - wc0, 32'd2);
        wc1 = we_count;
        repeat (100) @(posedge clk);
        #1;
        check("halt_no_writes", we_count - wc1, 32'd0);
        check("halt_held", {31'd0, halted}, 32'd1);
        check("halt_we_low", {31'd0, ram_write_enable}, 32'd0);
        check("halt_r0", {16'd0, dut.r_registers[0]}, 32'd0);
        check("halt_r1", {16'd0, dut.r_registers[1]}, 32'd1);
        check("halt_r2", {16'd0, dut.r_registers[2]}, 32'd2);
        check("halt_r3", {16'd0, dut.r_registers[3]}, {16'd0, exp_mul});

        // Sequence 2: reset asserted in the middle of a store's EXECUTE cycle.
        i_reset = 1'b0;
        load_word(8'd0, iform(3'd7, 4'd2, 8'd250));
        load_word(8'd1, 16'h0000);
        load_word(8'd250, 16'h1111);
        release_reset();
        n = 0;
        while (!ram_write_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sw_we_seen", {31'd0, ram_write_enable}, 32'd1);
        #1 i_reset = 1'b0;
        #1;
        check("midsw_we", {31'd0, ram_write_enable}, 32'd0);
        check("midsw_addr", {24'd0, ram_address}, 32'd0);
        check("midsw_wdata", {16'd0, ram_write_data}, 32'd0);
        @(posedge clk); #1;
        check("midsw_mem_kept", {16'd0, mem[250]}, 32'h1111);
        release_reset();
        wait_halt(20, "restart_halt");
        check("restart_mem", {16'd0, mem[250]}, 32'd2);
        check("restart_pc", {24'd0, dut.r_pc}, 32'd2);

        for (int i = 0; i < NUM_VECS; i++) run_vector(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
